// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester-side handshake bundle for one data memory port
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] wd;
  logic                  gnt;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd;

  modport master (output req, we, addr, funct3, wd, input gnt, ack, err, rd);
  modport slave  (input req, we, addr, funct3, wd, output gnt, ack, err, rd);
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter and access checker for the data memory
module data_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 256,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_arbiter_if.slave     port_a,
  data_mem_arbiter_if.slave     port_b,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_funct3,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  state_t                next_state;

  logic                  last_b;
  logic                  any_req;
  logic                  pick_b;

  logic                  in_we;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [2:0]            in_f3;
  logic [DATA_WIDTH-1:0] in_wd;
  logic                  in_err;

  logic [ADDR_WIDTH:0]   size;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  f3_err;
  logic                  range_err;
  logic                  align_err;

  logic                  lat_sel;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [2:0]            lat_f3;
  logic [DATA_WIDTH-1:0] lat_wd;
  logic                  lat_err;

  logic [DATA_WIDTH-1:0] rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_q;

  assign any_req = port_a.req | port_b.req;
  // B wins only when A is idle or A was the one served last
  assign pick_b  = port_b.req & (~port_a.req | ~last_b);

  assign in_we   = pick_b ? port_b.we     : port_a.we;
  assign in_addr = pick_b ? port_b.addr   : port_a.addr;
  assign in_f3   = pick_b ? port_b.funct3 : port_a.funct3;
  assign in_wd   = pick_b ? port_b.wd     : port_a.wd;

  always_comb begin
    size = (ADDR_WIDTH+1)'(4);
    case (in_f3[1:0])
      2'b00:   size = (ADDR_WIDTH+1)'(1);
      2'b01:   size = (ADDR_WIDTH+1)'(2);
      default: size = (ADDR_WIDTH+1)'(4);
    endcase
  end

  // one extra bit so an access near the top of the address space cannot wrap
  assign end_addr  = {1'b0, in_addr} + size;
  assign range_err = end_addr > (ADDR_WIDTH+1)'(MEM_BYTES);

  always_comb begin
    f3_err = 1'b0;
    if (in_we)
      f3_err = !(in_f3 inside {3'b000, 3'b001, 3'b010});
    else
      f3_err = !(in_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  end

  assign align_err = CHECK_ALIGN &&
                     (((in_f3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_f3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));

  assign in_err = f3_err | range_err | align_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b   <= 1'b1;
      lat_sel  <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_f3   <= '0;
      lat_wd   <= '0;
      lat_err  <= 1'b0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last_b   <= pick_b;
        lat_sel  <= pick_b;
        lat_we   <= in_we;
        lat_addr <= in_addr;
        lat_f3   <= in_f3;
        lat_wd   <= in_wd;
        lat_err  <= in_err;
      end
      // stores leave the requester's read register untouched
      if (state == ACCESS && !lat_we) begin
        if (lat_sel)
          rd_b_q <= lat_err ? '0 : mem_rd;
        else
          rd_a_q <= lat_err ? '0 : mem_rd;
      end
    end
  end

  always_comb begin
    port_a.gnt = 1'b0;
    port_b.gnt = 1'b0;
    port_a.ack = 1'b0;
    port_b.ack = 1'b0;
    port_a.err = 1'b0;
    port_b.err = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_funct3 = '0;
    mem_wd     = '0;
    case (state)
      ACCESS: begin
        port_a.gnt = ~lat_sel;
        port_b.gnt = lat_sel;
        mem_we     = lat_we & ~lat_err;
        mem_addr   = lat_addr;
        mem_funct3 = lat_f3;
        mem_wd     = lat_wd;
      end
      DONE: begin
        port_a.gnt = ~lat_sel;
        port_b.gnt = lat_sel;
        port_a.ack = ~lat_sel;
        port_b.ack = lat_sel;
        port_a.err = ~lat_sel & lat_err;
        port_b.err = lat_sel & lat_err;
      end
      default: ;
    endcase
  end

  assign port_a.rd = rd_a_q;
  assign port_b.rd = rd_b_q;

endmodule
